// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//
// Accepts an unsigned magnitude plus sign on a start request, converts it over
// WIDTH clock cycles, then presents registered BCD digits, sign and overflow
// together with a one-cycle done pulse.
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  conversion request, sampled only while idle
//   value_i  unsigned binary magnitude, sampled on the accepting edge
//   neg_i    sign of value_i (1 = negative), sampled with value_i
//   busy_o   high while converting or presenting the result
//   done_o   one-cycle pulse, result valid
//   bcd_o    result digits, units digit in bits [3:0]
//   sign_o   sign belonging to the current result
//   ovf_o    converted value was >= 10**DIGITS (bcd_o holds value mod 10**DIGITS)
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      value_i,
  input  logic                  neg_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  sign_o,
  output logic                  ovf_o
);

  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned WorkW = BcdW + WIDTH;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  localparam int unsigned Pow10 = pow10(DIGITS);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e             state_q, state_d;
  logic [WorkW-1:0]   work_q, work_d;     // {BCD field, binary field}
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BcdW-1:0]    bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;

  logic [WorkW-1:0]   work_adj;
  logic [WorkW-1:0]   work_shift;

  // Add-3 correction on every BCD nibble, then shift the whole register.
  // The carry out of the top nibble falls off, giving value mod 10**DIGITS.
  always_comb begin
    work_adj = work_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (work_q[WIDTH+4*d +: 4] >= 4'd5) begin
        work_adj[WIDTH+4*d +: 4] = work_q[WIDTH+4*d +: 4] + 4'd3;
      end
    end
    work_shift = work_adj << 1;
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          work_d     = {{BcdW{1'b0}}, value_i};
          neg_d      = neg_i;
          // Zero-extend to 32 bits for the threshold compare.
          ovf_pend_d = (32'(value_i) >= Pow10);
          cnt_d      = CntW'(WIDTH);
          state_d    = StConv;
        end
      end
      StConv: begin
        work_d = work_shift;
        cnt_d  = cnt_q - CntW'(1);
        // Last shift: publish the result on the edge that enters StDone.
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          bcd_d   = work_shift[WorkW-1 -: BcdW];
          sign_d  = neg_q;
          ovf_d   = ovf_pend_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      work_q     <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
    end
  end

  // Decoded from the state register only; no input reaches an output directly.
  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign bcd_o  = bcd_q;
  assign sign_o = sign_q;
  assign ovf_o  = ovf_q;

endmodule
